// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte-stream RAM loader with readback checksum verify
//
// Accepts CMD, ADDR, COUNT header bytes followed by COUNT payload bytes
// (COUNT 0 = 256), writes the payload to consecutive RAM addresses in the
// bank chosen by CMD bit0, then reads the range back and compares 8-bit sums.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_rxData/i_rxValid    incoming stream byte and its valid
//   o_rxReady             loader accepts the byte (handshake = valid & ready)
//   o_address/o_addressEn RAM address and address-register load strobe
//   o_writeData/o_writeEn RAM write data and write strobe
//   o_readDataSelect      RAM bank select (1 = data, 0 = program)
//   o_outEnable           RAM read enable
//   i_readData            RAM read data (combinational from registered address)
//   o_busy                loader owns the RAM
//   o_done                one-cycle pulse at the end of verify
//   o_error               readback checksum mismatch, held until next CMD byte

module ram_loader (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rxData,
  input  logic       i_rxValid,
  output logic       o_rxReady,
  output logic [7:0] o_address,
  output logic       o_addressEn,
  output logic [7:0] o_writeData,
  output logic       o_writeEn,
  output logic       o_readDataSelect,
  output logic       o_outEnable,
  input  logic [7:0] i_readData,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ADDR,
    S_HDR_COUNT,
    S_WRITE,
    S_RELOAD,
    S_READ,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_start;
  logic [8:0] r_count;
  logic [8:0] r_left;
  logic [7:0] r_wsum;
  logic [7:0] r_rsum;

  logic       w_hs;
  logic [7:0] w_rsum_next;

  assign w_hs        = i_rxValid & o_rxReady;
  assign w_rsum_next = r_rsum + i_readData;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_start          <= 8'h00;
      r_count          <= 9'd0;
      r_left           <= 9'd0;
      r_wsum           <= 8'h00;
      r_rsum           <= 8'h00;
      o_rxReady        <= 1'b0;
      o_address        <= 8'hFF;
      o_addressEn      <= 1'b0;
      o_writeData      <= 8'h00;
      o_writeEn        <= 1'b0;
      o_readDataSelect <= 1'b0;
      o_outEnable      <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      // strobes are single-cycle unless a state re-asserts them
      o_writeEn   <= 1'b0;
      o_addressEn <= 1'b0;
      o_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_rxReady <= 1'b1;
          if (w_hs) begin
            o_readDataSelect <= i_rxData[0];
            o_error          <= 1'b0;
            o_busy           <= 1'b1;
            r_state          <= S_HDR_ADDR;
          end
        end
        S_HDR_ADDR: begin
          if (w_hs) begin
            r_start <= i_rxData;
            r_state <= S_HDR_COUNT;
          end
        end
        S_HDR_COUNT: begin
          if (w_hs) begin
            r_count     <= (i_rxData == 8'h00) ? 9'd256 : {1'b0, i_rxData};
            r_left      <= (i_rxData == 8'h00) ? 9'd256 : {1'b0, i_rxData};
            // preload the RAM address so the first payload byte can be
            // written on the cycle right after its handshake
            o_address   <= r_start;
            o_addressEn <= 1'b1;
            r_wsum      <= 8'h00;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (o_rxReady) begin
            if (i_rxValid) begin
              o_writeData <= i_rxData;
              o_writeEn   <= 1'b1;
              o_address   <= o_address + 8'd1;
              o_addressEn <= 1'b1;
              r_wsum      <= r_wsum + i_rxData;
              r_left      <= r_left - 9'd1;
              if (r_left == 9'd1) begin
                o_rxReady <= 1'b0;
              end
            end
          end else begin
            // ready already dropped: this cycle carries the final write,
            // so point the RAM back at the start for readback
            o_address   <= r_start;
            o_addressEn <= 1'b1;
            o_outEnable <= 1'b1;
            r_rsum      <= 8'h00;
            r_left      <= r_count;
            r_state     <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          o_address   <= o_address + 8'd1;
          o_addressEn <= 1'b1;
          r_state     <= S_READ;
        end
        S_READ: begin
          r_rsum <= w_rsum_next;
          r_left <= r_left - 9'd1;
          if (r_left == 9'd1) begin
            o_outEnable <= 1'b0;
            o_done      <= 1'b1;
            o_error     <= (w_rsum_next != r_wsum);
            r_state     <= S_DONE;
          end else begin
            o_address   <= o_address + 8'd1;
            o_addressEn <= 1'b1;
          end
        end
        S_DONE: begin
          o_busy    <= 1'b0;
          o_rxReady <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
